// File: rtl/seq_det_pkg.sv
// Shared defaults for the parameterised serial sequence detector.
//   DEFAULT_MAX_LEN  : widest pattern the history register can hold
//   DEFAULT_CNT_W    : width of the saturating match counter
//   DEFAULT_PATTERN  : pattern loaded at reset, zero-extended to 32 bits.
//                      Bit DEFAULT_LEN-1 is the first bit received.
//   DEFAULT_LEN      : pattern length loaded at reset
package seq_det_pkg;

  localparam int          DEFAULT_MAX_LEN = 8;
  localparam int          DEFAULT_CNT_W   = 8;
  localparam logic [31:0] DEFAULT_PATTERN = 32'b110011;
  localparam int          DEFAULT_LEN     = 6;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears q
//   clr   : synchronous clear, takes priority over inc
//   inc   : count up by one unless already all ones
//   q     : current count
//   sat   : high while q is all ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             sat
);

  assign sat = &q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset, restores default pattern
//   in          : serial data bit, accepted when in_valid is high
//   in_valid    : qualifies in
//   overlap     : 1 = a match's tail may begin the next match
//   cfg_we      : load cfg_pattern / cfg_len this edge
//   cfg_pattern : new pattern, bit cfg_len-1 received first
//   cfg_len     : new pattern length, legal range 2..MAX_LEN
//   clr_cnt     : clear the match counter
//   out         : one-cycle pulse the cycle after the completing bit
//   match_cnt   : saturating number of matches
//   cnt_sat     : high while match_cnt is all ones
//   cfg_err     : one-cycle pulse after a rejected configuration write
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int                 CNT_W       = DEFAULT_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEFAULT_PATTERN),
  parameter int                 DEF_LEN     = DEFAULT_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in,
  input  logic                     in_valid,
  input  logic                     overlap,
  input  logic                     cfg_we,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     clr_cnt,
  output logic                     out,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cnt_sat,
  output logic                     cfg_err
);

  localparam int               LEN_W    = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len;
  logic               cfg_len_ok;
  logic               cfg_accept;
  logic               fill_ok;
  logic               hit_next;

  // History as it will look once the current bit is shifted in.
  assign shifted = {history[MAX_LEN-2:0], in};

  // NOTE: every variable assigned in always_comb gets a default first so
  // no path leaves it holding its old value, which would infer a latch.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign cfg_len_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= FILL_MAX);
  assign cfg_accept = cfg_we && cfg_len_ok;

  // len is never below 2, so len-1 cannot underflow; fill >= len-1 is the
  // same test as "this bit brings the count of usable bits up to len".
  assign fill_ok = (fill >= len - LEN_W'(1));

  // An accepted configuration write discards the bit arriving with it.
  assign hit_next = in_valid && !cfg_accept && fill_ok &&
                    ((shifted & mask) == (pattern & mask));

  always_ff @(posedge clk) begin
    if (reset) begin
      history <= '0;
      fill    <= '0;
      out     <= 1'b0;
      cfg_err <= 1'b0;
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
    end else begin
      out     <= hit_next;
      cfg_err <= cfg_we && !cfg_len_ok;
      if (cfg_accept) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        history <= '0;
        fill    <= '0;
      end else if (in_valid) begin
        history <= shifted;
        // Without overlap the completing bit must not start the next match,
        // so a hit forgets every bit seen so far.
        if (hit_next && !overlap) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (hit_next),
    .q     (match_cnt),
    .sat   (cnt_sat)
  );

endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param. Two instances share every input:
// one with default parameters and one with a 2-bit match counter, so that
// saturation is reachable quickly. Expected values come from a bit-queue
// reference model that applies the detector's rules directly.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in = 1'b0;
  logic             in_valid = 1'b0;
  logic             overlap = 1'b1;
  logic             cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             clr_cnt = 1'b0;

  logic             out;
  logic [7:0]       match_cnt;
  logic             cnt_sat;
  logic             cfg_err;
  logic             out_s;
  logic [1:0]       match_cnt_s;
  logic             cnt_sat_s;
  logic             cfg_err_s;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit q_bits[$];
  int m_pat;
  int m_len;
  int m_cnt;
  int m_cnt_s;
  bit e_out;
  bit e_err;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_valid    (in_valid),
    .overlap     (overlap),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .clr_cnt     (clr_cnt),
    .out         (out),
    .match_cnt   (match_cnt),
    .cnt_sat     (cnt_sat),
    .cfg_err     (cfg_err)
  );

  seq_detect_param #(
    .CNT_W (2)
  ) dut_small (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_valid    (in_valid),
    .overlap     (overlap),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .clr_cnt     (clr_cnt),
    .out         (out_s),
    .match_cnt   (match_cnt_s),
    .cnt_sat     (cnt_sat_s),
    .cfg_err     (cfg_err_s)
  );

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_edge();
    bit hit;
    int v;
    hit = 1'b0;
    if (reset) begin
      q_bits.delete();
      m_pat   = 'b110011;
      m_len   = 6;
      m_cnt   = 0;
      m_cnt_s = 0;
      e_out   = 1'b0;
      e_err   = 1'b0;
      return;
    end
    e_err = cfg_we && (int'(cfg_len) < 2 || int'(cfg_len) > MAX_LEN);
    if (cfg_we && !e_err) begin
      m_pat = int'(cfg_pattern);
      m_len = int'(cfg_len);
      q_bits.delete();
    end else if (in_valid) begin
      q_bits.push_back(in);
      if (q_bits.size() > MAX_LEN) void'(q_bits.pop_front());
      if (q_bits.size() >= m_len) begin
        v = 0;
        for (int i = q_bits.size() - m_len; i < q_bits.size(); i++) begin
          v = (v << 1) | int'(q_bits[i]);
        end
        hit = (v == (m_pat & ((1 << m_len) - 1)));
      end
      if (hit && !overlap) q_bits.delete();
    end
    e_out = hit;
    if (clr_cnt) begin
      m_cnt   = 0;
      m_cnt_s = 0;
    end else if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
  endtask

  // Apply one bit (or an idle cycle) across a clock edge. Control strobes
  // set by the caller beforehand are dropped again after the edge.
  task automatic step(input logic b, input logic v);
    in       = b;
    in_valid = v;
    model_edge();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    clr_cnt  = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    cfg_we  = 1'b1;
    cfg_len = 4'd3;
    clr_cnt = 1'b1;
    do_reset();
    checks++;
    if (out !== 1'b0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out=%b cnt=%0d sat=%b err=%b, want 0/0/0/0",
               out, match_cnt, cnt_sat, cfg_err);
    end
  endtask

  task automatic test_stream(input logic ovl, input int want_pulses);
    logic [9:0] stream;
    int pulses;
    stream  = 10'b1100110011;
    pulses  = 0;
    overlap = ovl;
    do_reset();
    for (int i = 9; i >= 0; i--) begin
      step(stream[i], 1'b1);
      if (out === 1'b1) pulses++;
      checks++;
      if (out !== e_out) begin
        failures++;
        $display("FAIL stream_ovl%0b_bit%0d: out=%b want %b", ovl, 10 - i, out, e_out);
      end
    end
    checks++;
    if (pulses != want_pulses || match_cnt !== 8'(want_pulses)) begin
      failures++;
      $display("FAIL stream_ovl%0b_total: pulses=%0d cnt=%0d want %0d", ovl, pulses,
               match_cnt, want_pulses);
    end
  endtask

  task automatic test_gap();
    logic [5:0] stream;
    int pulses;
    stream  = 6'b110011;
    pulses  = 0;
    overlap = 1'b1;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      if (i == 2) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b1, 1'b0);
          checks++;
          if (out !== 1'b0) begin
            failures++;
            $display("FAIL gap_idle%0d: out=%b want 0", g, out);
          end
        end
      end
      step(stream[i], 1'b1);
      if (out === 1'b1) pulses++;
      checks++;
      if (out !== e_out) begin
        failures++;
        $display("FAIL gap_bit%0d: out=%b want %b", 6 - i, out, e_out);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL gap_total: pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_cfg();
    logic [4:0] stream;
    int pulses;
    stream = 5'b10101;
    pulses = 0;
    do_reset();
    overlap     = 1'b1;
    // Upper bits are junk that a length of 3 must ignore.
    cfg_pattern = 8'b1100_0101;
    cfg_len     = 4'd3;
    cfg_we      = 1'b1;
    step(1'b1, 1'b1);
    checks++;
    if (out !== 1'b0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL cfg_load: out=%b err=%b want 0/0", out, cfg_err);
    end
    for (int i = 4; i >= 0; i--) begin
      step(stream[i], 1'b1);
      if (out === 1'b1) pulses++;
      checks++;
      if (out !== e_out) begin
        failures++;
        $display("FAIL cfg_bit%0d: out=%b want %b", 5 - i, out, e_out);
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL cfg_total: pulses=%0d want 2", pulses);
    end
    // Rejected lengths: too short, then too long.
    for (int k = 0; k < 2; k++) begin
      cfg_pattern = 8'b0000_0011;
      cfg_len     = (k == 0) ? 4'd1 : 4'd9;
      cfg_we      = 1'b1;
      step(1'b0, 1'b0);
      checks++;
      if (cfg_err !== 1'b1 || cfg_err_s !== 1'b1) begin
        failures++;
        $display("FAIL cfg_err_len%0d: err=%b want 1", cfg_len, cfg_err);
      end
    end
    step(1'b0, 1'b0);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL cfg_err_pulse: err=%b want 0", cfg_err);
    end
    // Old 101 config and history survive: history ends ...01, so 0,1 hits.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    checks++;
    if (out !== 1'b1 || e_out !== 1'b1) begin
      failures++;
      $display("FAIL cfg_kept: out=%b model=%b want 1", out, e_out);
    end
    // A bit arriving with an accepted write is discarded.
    cfg_pattern = 8'b0000_0011;
    cfg_len     = 4'd2;
    cfg_we      = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL cfg_discard: out=%b want 0", out);
    end
    step(1'b1, 1'b1);
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL cfg_after_discard: out=%b want 1", out);
    end
  endtask

  task automatic test_saturate();
    logic [17:0] stream;
    stream  = 18'b110011_0011_0011_0011;
    overlap = 1'b1;
    do_reset();
    for (int i = 17; i >= 0; i--) step(stream[i], 1'b1);
    checks++;
    if (match_cnt_s !== 2'd3 || cnt_sat_s !== 1'b1 || match_cnt !== 8'd4 || cnt_sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_count: small=%0d/%b big=%0d/%b want 3/1 4/0",
               match_cnt_s, cnt_sat_s, match_cnt, cnt_sat);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    clr_cnt = 1'b1;
    step(1'b1, 1'b1);
    checks++;
    if (out !== 1'b1 || match_cnt !== 8'd0 || match_cnt_s !== 2'd0 || cnt_sat_s !== 1'b0) begin
      failures++;
      $display("FAIL clr_with_hit: out=%b cnt=%0d small=%0d sat=%b want 1/0/0/0",
               out, match_cnt, match_cnt_s, cnt_sat_s);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] head;
    logic [5:0] full;
    int pulses;
    head    = 5'b11001;
    full    = 6'b110011;
    pulses  = 0;
    overlap = 1'b1;
    // Load a different config first so the reset must restore 110011.
    cfg_pattern = 8'b0000_0001;
    cfg_len     = 4'd2;
    cfg_we      = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) step(head[i], 1'b1);
    do_reset();
    step(1'b1, 1'b1);
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: out=%b want 0", out);
    end
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      step(full[i], 1'b1);
      if (out === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || out !== 1'b1) begin
      failures++;
      $display("FAIL reset_default_pattern: pulses=%0d last_out=%b want 1/1", pulses, out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if ($urandom_range(0, 39) == 0) overlap = ~overlap;
      if ($urandom_range(0, 59) == 0) clr_cnt = 1'b1;
      if ($urandom_range(0, 79) == 0) begin
        cfg_we      = 1'b1;
        cfg_pattern = 8'($urandom);
        cfg_len     = 4'($urandom_range(0, 10));
        if (cfg_len > 4'd4 && $urandom_range(0, 1) == 0) cfg_len = 4'($urandom_range(2, 4));
      end
      if (cfg_we && (cfg_len < 4'd2 || cfg_len > 4'd8)) begin
        step(1'($urandom), 1'b0);
      end else begin
        step(1'($urandom), ($urandom_range(0, 3) != 0));
      end
      checks++;
      if (out !== e_out || out_s !== e_out || match_cnt !== 8'(m_cnt) ||
          match_cnt_s !== 2'(m_cnt_s) || cnt_sat !== (m_cnt == 255) ||
          cnt_sat_s !== (m_cnt_s == 3) || cfg_err !== e_err || cfg_err_s !== e_err) begin
        failures++;
        $display("FAIL random_cycle%0d: out=%b/%b cnt=%0d/%0d sat=%b/%b err=%b want out=%b cnt=%0d/%0d err=%b",
                 n, out, out_s, match_cnt, match_cnt_s, cnt_sat, cnt_sat_s, cfg_err,
                 e_out, m_cnt, m_cnt_s, e_err);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stream(1'b1, 2);
    test_stream(1'b0, 1);
    test_gap();
    test_cfg();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_detect_param
